// File: rtl/pi_ctrl_pkg.sv
// Shared definitions for the fixed-point PI controller: Q-format constants,
// saturate/clamp helpers and the pipeline stage-valid type.
package pi_ctrl_pkg;

  localparam int unsigned DEF_FRAC_BITS = 12;
  localparam int unsigned ONE           = 1 << DEF_FRAC_BITS;

  // Wide working width for the width-generic helpers below.
  localparam int unsigned CALC_W = 128;
  typedef logic signed [CALC_W-1:0] calc_t;

  // One valid bit per pipeline stage; s3 is the output stage.
  typedef struct packed {
    logic s1;
    logic s2;
    logic s3;
  } pipe_vld_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Saturate a value to the signed range of 'width' bits.
  function automatic calc_t sat_signed(input calc_t value, input int unsigned width);
    calc_t hi;
    calc_t lo;
    calc_t res;
    hi  = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
    lo  = -hi - calc_t'(1);
    res = value;
    if (value > hi) res = hi;
    if (value < lo) res = lo;
    return res;
  endfunction

  // Clamp a value into [lo, hi].
  function automatic calc_t clamp(input calc_t value, input calc_t lo, input calc_t hi);
    calc_t res;
    res = value;
    if (value > hi) res = hi;
    if (value < lo) res = lo;
    return res;
  endfunction

endpackage

// File: rtl/pi_sat_accum.sv
// Saturating integrator: adds di when enabled and not held; clear wins.
// integ_new_c_o is the value the register takes at the next edge.
module pi_sat_accum
  import pi_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned DI_W  = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    hold_i,
  input  logic                    clr_i,
  input  logic signed [DI_W-1:0]  di_i,
  output logic signed [ACC_W-1:0] integ_new_c_o
);

  localparam int unsigned ADD_W = max_u(ACC_W, DI_W) + 1;

  logic signed [ACC_W-1:0] integ_q;
  logic signed [ACC_W-1:0] integ_d;
  logic signed [ADD_W-1:0] add_raw;

  // Next integrator value: clear, saturating add, or hold.
  always_comb begin
    add_raw = ADD_W'(integ_q) + ADD_W'(di_i);
    integ_d = integ_q;
    if (clr_i) begin
      integ_d = '0;
    end else if (en_i && !hold_i) begin
      integ_d = ACC_W'(sat_signed(CALC_W'(add_raw), ACC_W));
    end
  end

  assign integ_new_c_o = integ_d;

  // Integrator state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      integ_q <= '0;
    end else begin
      integ_q <= integ_d;
    end
  end

endmodule

// File: rtl/pi_controller_fx.sv
// Three-stage fixed-point PI controller with Q-format runtime gains,
// saturating integrator, output clamp and conditional-integration anti-windup.
// Optional derivative term enabled by defining PI_D_TERM_EN (adds port kd).
module pi_controller_fx
  import pi_ctrl_pkg::*;
#(
  parameter int unsigned              DATA_W    = 32,
  parameter int unsigned              GAIN_W    = 18,
  parameter int unsigned              FRAC_BITS = DEF_FRAC_BITS,
  parameter int unsigned              ACC_W     = 40,
  parameter logic signed [DATA_W-1:0] OUT_MAX   = {1'b0, {(DATA_W-1){1'b1}}},
  parameter logic signed [DATA_W-1:0] OUT_MIN   = {1'b1, {(DATA_W-1){1'b0}}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] error,
  input  logic signed [GAIN_W-1:0] kp,
  input  logic signed [GAIN_W-1:0] ki,
`ifdef PI_D_TERM_EN
  input  logic signed [GAIN_W-1:0] kd,
`endif
  input  logic                     int_clr,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out,
  output logic                     sat_hi,
  output logic                     sat_lo
);

  localparam int unsigned PROD_W  = DATA_W + GAIN_W;
  localparam int unsigned P_W     = PROD_W - FRAC_BITS;
`ifdef PI_D_TERM_EN
  localparam int unsigned DIFF_W  = DATA_W + 1;
  localparam int unsigned DPROD_W = DIFF_W + GAIN_W;
  localparam int unsigned D_W     = DPROD_W - FRAC_BITS;
  localparam int unsigned SUM_W   = max_u(max_u(ACC_W, P_W), D_W) + 2;
`else
  localparam int unsigned SUM_W   = max_u(ACC_W, P_W) + 1;
`endif
  localparam logic signed [SUM_W-1:0] MAX_EXT = SUM_W'(OUT_MAX);
  localparam logic signed [SUM_W-1:0] MIN_EXT = SUM_W'(OUT_MIN);

  pipe_vld_t               vld_q;
  logic signed [P_W-1:0]   p_q;
  logic signed [P_W-1:0]   di_q;
  logic signed [P_W-1:0]   p_d;
  logic signed [P_W-1:0]   di_d;
  logic signed [ACC_W-1:0] integ_new;
  logic                    hold;
  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] sum_d;
  logic signed [DATA_W-1:0] out_q;
  logic signed [DATA_W-1:0] out_d;
  logic                    sat_hi_q;
  logic                    sat_lo_q;
  logic                    hi_d;
  logic                    lo_d;

  // S1 products: full-width multiply, arithmetic shift (floor).
  assign p_d  = P_W'((PROD_W'(error) * PROD_W'(kp)) >>> FRAC_BITS);
  assign di_d = P_W'((PROD_W'(error) * PROD_W'(ki)) >>> FRAC_BITS);

`ifdef PI_D_TERM_EN
  logic signed [DATA_W-1:0] prev_error_q;
  logic signed [D_W-1:0]    d_q;
  logic signed [D_W-1:0]    d_d;

  assign d_d = D_W'((DPROD_W'(DIFF_W'(error) - DIFF_W'(prev_error_q)) * DPROD_W'(kd)) >>> FRAC_BITS);

  // Derivative term and previous-error history.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_error_q <= '0;
      d_q          <= '0;
    end else begin
      if (in_valid) begin
        d_q <= d_d;
      end
      if (int_clr) begin
        prev_error_q <= '0;
      end else if (in_valid) begin
        prev_error_q <= error;
      end
    end
  end
`endif

  // Stage-valid shift register; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q.s1 <= in_valid;
      vld_q.s2 <= vld_q.s1;
      vld_q.s3 <= vld_q.s2;
    end
  end

  // S1 payload capture; gains only matter on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q  <= '0;
      di_q <= '0;
    end else if (in_valid) begin
      p_q  <= p_d;
      di_q <= di_d;
    end
  end

  // Anti-windup: skip integration that would push further into saturation.
  assign hold = (sat_hi_q && !di_q[P_W-1] && (di_q != '0)) ||
                (sat_lo_q &&  di_q[P_W-1]);

  pi_sat_accum #(
    .ACC_W (ACC_W),
    .DI_W  (P_W)
  ) u_accum (
    .clk           (clk),
    .rst           (rst),
    .en_i          (vld_q.s1),
    .hold_i        (hold),
    .clr_i         (int_clr),
    .di_i          (di_q),
    .integ_new_c_o (integ_new)
  );

`ifdef PI_D_TERM_EN
  assign sum_d = SUM_W'(p_q) + SUM_W'(integ_new) + SUM_W'(d_q);
`else
  assign sum_d = SUM_W'(p_q) + SUM_W'(integ_new);
`endif

  // S2 sum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (vld_q.s1) begin
      sum_q <= sum_d;
    end
  end

  assign hi_d  = (sum_q > MAX_EXT);
  assign lo_d  = (sum_q < MIN_EXT);
  assign out_d = DATA_W'(clamp(CALC_W'(sum_q), CALC_W'(OUT_MIN), CALC_W'(OUT_MAX)));

  // S3 clamped output and saturation flags, held between samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else if (vld_q.s2) begin
      out_q    <= out_d;
      sat_hi_q <= hi_d;
      sat_lo_q <= lo_d;
    end
  end

  assign out_valid = vld_q.s3;
  assign out       = out_q;
  assign sat_hi    = sat_hi_q;
  assign sat_lo    = sat_lo_q;

endmodule

// File: tb/tb_pi_controller_fx.sv
// Directed bench for pi_controller_fx (output clamp set to +/-250).
module tb_pi_controller_fx;
  import pi_ctrl_pkg::*;

  localparam logic signed [17:0] G1 = 18'(ONE);

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [31:0] error;
  logic signed [17:0] kp;
  logic signed [17:0] ki;
`ifdef PI_D_TERM_EN
  logic signed [17:0] kd;
`endif
  logic               int_clr;
  logic               out_valid;
  logic signed [31:0] out;
  logic               sat_hi;
  logic               sat_lo;

  int n_chk  = 0;
  int n_pass = 0;

  int burst_e   [8] = '{50, 50, 50, 50, 50, 50, 50, -100};
  int burst_out [8] = '{100, 150, 200, 250, 250, 250, 250, 100};
  int burst_hi  [8] = '{0, 0, 0, 0, 1, 1, 1, 0};

  pi_controller_fx #(
    .DATA_W    (32),
    .GAIN_W    (18),
    .FRAC_BITS (12),
    .ACC_W     (40),
    .OUT_MAX   (32'sd250),
    .OUT_MIN   (-32'sd250)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .error     (error),
    .kp        (kp),
    .ki        (ki),
`ifdef PI_D_TERM_EN
    .kd        (kd),
`endif
    .int_clr   (int_clr),
    .out_valid (out_valid),
    .out       (out),
    .sat_hi    (sat_hi),
    .sat_lo    (sat_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    int_clr = 1'b1;
    tick();
    int_clr = 1'b0;
  endtask

  // One sample; checks latency, value, flags and single-cycle pulse.
  task automatic run_sample(input string tag, input int e, input logic signed [17:0] kpv,
                            input logic signed [17:0] kiv, input int exp_o,
                            input logic exp_hi, input logic exp_lo, input logic clr_s2);
    int  lat;
    bit  seen;
    error    = e;
    kp       = kpv;
    ki       = kiv;
    in_valid = 1'b1;
    lat      = 0;
    seen     = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      in_valid = 1'b0;
      int_clr  = (c == 0) && clr_s2;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    int_clr = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'(3));
    check({tag, "_out"}, 64'(out), 64'(exp_o));
    check({tag, "_hi"}, 64'(sat_hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(sat_lo), 64'(exp_lo));
    tick();
    check({tag, "_pulse"}, 64'(out_valid), 64'(0));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  seen;
    rst      = 1'b1;
    in_valid = 1'b0;
    error    = '0;
    kp       = '0;
    ki       = '0;
    int_clr  = 1'b0;
`ifdef PI_D_TERM_EN
    kd       = '0;
`endif
    tick();
    tick();
    check("rst_out", 64'(out), 64'(0));
    check("rst_vld", 64'(out_valid), 64'(0));
    check("rst_hi", 64'(sat_hi), 64'(0));
    check("rst_lo", 64'(sat_lo), 64'(0));
    rst = 1'b0;
    tick();

    // Proportional path; -7*2048/4096 = -3.5 floors to -4.
    run_sample("p_unity", 100, G1, 18'sd0, 100, 1'b0, 1'b0, 1'b0);
    run_sample("p_floor", -7, 18'sd2048, 18'sd0, -4, 1'b0, 1'b0, 1'b0);

    // Integral with clamp/anti-windup: di = 410000>>>12 = 100.
    run_sample("i_1", 1000, 18'sd0, 18'sd410, 100, 1'b0, 1'b0, 1'b0);
    run_sample("i_2", 1000, 18'sd0, 18'sd410, 200, 1'b0, 1'b0, 1'b0);
    run_sample("i_3", 1000, 18'sd0, 18'sd410, 250, 1'b1, 1'b0, 1'b0);
    run_sample("i_hold", 1000, 18'sd0, 18'sd410, 250, 1'b1, 1'b0, 1'b0);
    // integ held at 300; -410000>>>12 floors to -101 -> 199.
    run_sample("i_unwind", -1000, 18'sd0, 18'sd410, 199, 1'b0, 1'b0, 1'b0);

    // Lower/upper clamp with extreme gains; then a negative gain.
    clr_pulse();
    tick();
    run_sample("lo_clamp", -300, G1, 18'sd0, -250, 1'b0, 1'b1, 1'b0);
    run_sample("lo_big", -1000000, 18'sd131071, 18'sd0, -250, 1'b0, 1'b1, 1'b0);
    run_sample("hi_big", 1000000, 18'sd131071, 18'sd0, 250, 1'b1, 1'b0, 1'b0);
    run_sample("neg_gain", 1, -18'sd131072, 18'sd0, -32, 1'b0, 1'b0, 1'b0);

    // int_clr coincident with S2: output is p only, then integration restarts.
    run_sample("clr_pre", 100, 18'sd0, G1, 100, 1'b0, 1'b0, 1'b0);
    run_sample("clr_s2", 20, G1, G1, 20, 1'b0, 1'b0, 1'b1);
    run_sample("clr_post", 20, G1, G1, 40, 1'b0, 1'b0, 1'b0);

    // Back-to-back burst; anti-windup sees flags lagged by two samples.
    clr_pulse();
    tick();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          error    = burst_e[k];
          kp       = G1;
          ki       = G1;
          in_valid = 1'b1;
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        w = 0;
        while (!out_valid && w < 12) begin
          tick();
          w++;
        end
        check("burst_lat", 64'(w), 64'(3));
        for (int k = 0; k < 8; k++) begin
          check($sformatf("burst_vld%0d", k), 64'(out_valid), 64'(1));
          check($sformatf("burst_out%0d", k), 64'(out), 64'(burst_out[k]));
          check($sformatf("burst_hi%0d", k), 64'(sat_hi), 64'(burst_hi[k]));
          tick();
        end
        check("burst_end", 64'(out_valid), 64'(0));
      end
    join
    tick();

    // Reset with two samples in flight: nothing emerges, state cleared.
    error    = 10;
    kp       = G1;
    ki       = G1;
    in_valid = 1'b1;
    tick();
    error = 20;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out", 64'(out), 64'(0));
    check("mid_rst_vld", 64'(out_valid), 64'(0));
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_drop", 64'(seen), 64'(0));
    run_sample("post_rst", 100, 18'sd0, G1, 100, 1'b0, 1'b0, 1'b0);

`ifdef PI_D_TERM_EN
    // Derivative only: errors 10 then 30 -> 10 then 20.
    clr_pulse();
    tick();
    kd = G1;
    run_sample("d_1", 10, 18'sd0, 18'sd0, 10, 1'b0, 1'b0, 1'b0);
    run_sample("d_2", 30, 18'sd0, 18'sd0, 20, 1'b0, 1'b0, 1'b0);
    kd = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
